module_gpio_irq_controller: RTL
===============================

// Module: module_gpio_irq_controller
// PURPOSE
// - Turns asynchronous GPIO pins into prioritised CPU interrupt requests.
// - Each pin passes through a synchronizer. Its rise and fall pulses are masked per line and latched into a pending register.
// - A round-robin scheduler presents one pending line at a time to the core, using an irq/irq_ack handshake.
// - Sits between the GPIO pads and the core's external-interrupt input.
// PARAMETERS
// - LEN     8  number of GPIO lines (2..32)
// - STAGES  2  synchronizer flip-flop stages per line (>=2)
// PORTS
// - clk        in   1            system clock; all logic on rising edge
// - reset_n    in   1            asynchronous, active-low reset
// - en         in   1            arbitration enable; edge capture runs regardless
// - pins_in    in   LEN          raw asynchronous pin levels
// - rise_mask  in   LEN          1 = rising edge on line i raises an event
// - fall_mask  in   LEN          1 = falling edge on line i raises an event
// - clear      in   LEN          software clear of pending bits (single-cycle strobe)
// - pending    out  LEN          latched, not-yet-serviced events
// - irq        out  1            interrupt request to core
// - irq_id     out  $clog2(LEN)  index of line being requested; valid while irq=1
// - irq_ack    in   1            core acknowledge; sampled only while irq=1
// - pins_sync  out  LEN          synchronized pin levels (for GPIO read-back)
// BEHAVIOUR
// - Reset values: pending=0, irq=0, irq_id=0, pins_sync=0, overrun=0, state=IDLE, rr_ptr=LEN-1 (line 0 has first priority).
// - Synchronizer enable is tied to 1, so edges are never lost while en=0.
// - event[i] = (rise[i] & rise_mask[i]) | (fall[i] & fall_mask[i]).
// - pending_next = (pending & ~clear & ~ack_clr) | event. On the same cycle, a set beats a clear.
// - Latency: pending[i] sets on the edge where the synchronizer rise/fall pulse is high. irq rises on the next edge, at the earliest.
// - FSM IDLE: if en=1 and pending!=0, grant the first set bit scanning upward from rr_ptr+1 with wrap (LEN-1 -> 0).
//   Register irq_id=grant, set irq=1, go to REQ.
// - FSM REQ: irq and irq_id are held stable; a change in en or pending does not alter them.
//   On irq_ack=1: clear pending[irq_id] (unless event[irq_id] fires the same cycle), set rr_ptr=irq_id, irq=0, go to IDLE.
// - Minimum one IDLE cycle between consecutive requests. Back-to-back service of N lines takes 2N cycles.
// - clear[irq_id] during REQ: the bit clears, but the request stays up until acked. The ack then has no pending side effect.
// - irq_ack in IDLE is ignored.
// - en deasserted in REQ: the current request completes normally. No new grant while en=0.
// - reset_n asserted mid-request: irq drops asynchronously and all state returns to reset values.
// CONFIGURATION
// - GPIO_IRQ_OVERRUN_EN defined: adds output overrun[LEN].
//   overrun[i] sets when event[i] fires while pending[i] is already 1. It clears only via clear[i].
//   A set beats a clear, as for pending.
// - Macro undefined: no overrun port or register. Repeated events on a pending line merge silently.
// STRUCTURE
// - Package gpio_irq_pkg:
//   - typedef enum logic {IDLE, REQ} gpio_irq_state_t;
//   - MAX_LEN=32 constant;
//   - function rr_pick(pending, ptr) returning the grant index.
// - Sub-module: LEN-wide module_synchronizer (LEN, STAGES) instance producing pins_sync/rise/fall.
// - Top holds the pending/overrun registers, FSM and round-robin pointer.
// TESTING
// - Reset, pins_in=0, all masks=1: after 5 cycles, pending=0, irq=0, pins_sync=0.
// - rise_mask=8'h01, pins_in[0] 0->1: pending=8'h01 within STAGES+1 cycles, then irq=1, irq_id=0.
//   Ack gives pending=0, irq=0.
// - pending=8'h05 and rr_ptr=0: first grant irq_id=2, after ack irq_id=0, after ack irq=0. Confirms round-robin wrap.
// - en=0 with pending=8'h10: irq stays 0 for 20 cycles. Raising en gives irq=1, irq_id=4 on the next edge.
// - irq_id=3 in REQ, new rise event on line 3 in the same cycle as irq_ack: pending[3] stays 1 and irq reasserts with id 3.
// - GPIO_IRQ_OVERRUN_EN: two rises on line 1 with no ack give overrun=8'h02. clear=8'h02 gives pending=0 and overrun=0.

Source files
------------

// File: rtl/module_gpio_irq_controller_pkg.sv
// Shared types, constants and the round-robin grant helper for the GPIO interrupt controller.
package gpio_irq_pkg;

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} gpio_irq_state_t;

   localparam int MAX_LEN = 32;
   localparam int PTR_W   = 5;

   // First set bit scanning upward from ptr+1, wrapping at len-1 back to 0.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_LEN-1:0] pend,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int                 len);
      logic [PTR_W-1:0] grant;
      logic [PTR_W:0]   idx;
      logic             found;
      grant = ptr;
      found = 1'b0;
      for (int k = 1; k <= MAX_LEN; k++) begin
         if (k <= len) begin
            idx = {1'b0, ptr} + 6'(k);
            if (idx >= 6'(len)) begin
               idx = idx - 6'(len);
            end else begin
               idx = idx;
            end
            if (!found && pend[idx[PTR_W-1:0]]) begin
               grant = idx[PTR_W-1:0];
               found = 1'b1;
            end else begin
               found = found;
            end
         end else begin
            idx = '0;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/module_gpio_irq_controller_synchronizer.sv
// Multi-stage pin synchronizer with single-cycle rise/fall pulses; always enabled so no edge is lost.
module module_synchronizer #(
   parameter int LEN    = 8,
   parameter int STAGES = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [LEN-1:0] din,
   output logic [LEN-1:0] dout,
   output logic [LEN-1:0] rise,
   output logic [LEN-1:0] fall
);

   logic [LEN-1:0] chain_r [STAGES];
   logic [LEN-1:0] prev_r;

   // Shift chain plus one history stage for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < STAGES; s++) begin
            chain_r[s] <= '0;
         end
         prev_r <= '0;
      end else begin
         chain_r[0] <= din;
         for (int s = 1; s < STAGES; s++) begin
            chain_r[s] <= chain_r[s-1];
         end
         prev_r <= chain_r[STAGES-1];
      end
   end

   assign dout = chain_r[STAGES-1];
   assign rise = dout & ~prev_r;
   assign fall = ~dout & prev_r;

endmodule

// File: rtl/module_gpio_irq_controller.sv
// GPIO edge capture into pending bits with round-robin irq/irq_ack delivery.
// Optional GPIO_IRQ_OVERRUN_EN adds a per-line overrun flag for events hitting an already pending line.
module module_gpio_irq_controller
   import gpio_irq_pkg::*;
#(
   parameter int LEN    = 8,
   parameter int STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   en,
   input  logic [LEN-1:0]         pins_in,
   input  logic [LEN-1:0]         rise_mask,
   input  logic [LEN-1:0]         fall_mask,
   input  logic [LEN-1:0]         clear,
   output logic [LEN-1:0]         pending,
   output logic                   irq,
   output logic [$clog2(LEN)-1:0] irq_id,
   input  logic                   irq_ack,
`ifdef GPIO_IRQ_OVERRUN_EN
   output logic [LEN-1:0]         overrun,
`endif
   output logic [LEN-1:0]         pins_sync
);

   localparam int ID_W = $clog2(LEN);

   logic [LEN-1:0]     rise_s, fall_s, event_s, ack_clr_s, pending_r;
   logic [MAX_LEN-1:0] pend_ext_s;
   logic [PTR_W-1:0]   grant_s;
   gpio_irq_state_t    state_r, state_next_s;
   logic               irq_r, irq_next_s;
   logic [ID_W-1:0]    irq_id_r, irq_id_next_s, rr_ptr_r, rr_ptr_next_s;

   module_synchronizer #(.LEN(LEN), .STAGES(STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (pins_in),
      .dout    (pins_sync),
      .rise    (rise_s),
      .fall    (fall_s)
   );

   assign event_s = (rise_s & rise_mask) | (fall_s & fall_mask);

   // Round-robin candidate from the current pending set.
   always_comb begin
      pend_ext_s = '0;
      pend_ext_s[LEN-1:0] = pending_r;
      grant_s = rr_pick(pend_ext_s, PTR_W'(rr_ptr_r), LEN);
   end

   // Next-state logic: request held stable in REQ until acknowledged.
   always_comb begin
      state_next_s  = state_r;
      irq_next_s    = irq_r;
      irq_id_next_s = irq_id_r;
      rr_ptr_next_s = rr_ptr_r;
      ack_clr_s     = '0;
      case (state_r)
         IDLE: begin
            if (en && (pending_r != '0)) begin
               state_next_s  = REQ;
               irq_next_s    = 1'b1;
               irq_id_next_s = ID_W'(grant_s);
            end else begin
               state_next_s = IDLE;
               irq_next_s   = 1'b0;
            end
         end
         REQ: begin
            if (irq_ack) begin
               ack_clr_s[irq_id_r] = 1'b1;
               rr_ptr_next_s       = irq_id_r;
               irq_next_s          = 1'b0;
               state_next_s        = IDLE;
            end else begin
               state_next_s = REQ;
            end
         end
         default: begin
            state_next_s = IDLE;
            irq_next_s   = 1'b0;
         end
      endcase
   end

   // State, request and pending registers; a new event wins over any clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         irq_r     <= 1'b0;
         irq_id_r  <= '0;
         rr_ptr_r  <= ID_W'(LEN - 1);
         pending_r <= '0;
      end else begin
         state_r   <= state_next_s;
         irq_r     <= irq_next_s;
         irq_id_r  <= irq_id_next_s;
         rr_ptr_r  <= rr_ptr_next_s;
         pending_r <= (pending_r & ~clear & ~ack_clr_s) | event_s;
      end
   end

`ifdef GPIO_IRQ_OVERRUN_EN
   logic [LEN-1:0] overrun_r;

   // Sticky overrun: only software clear removes it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_r <= '0;
      end else begin
         overrun_r <= (overrun_r & ~clear) | (event_s & pending_r);
      end
   end

   assign overrun = overrun_r;
`endif

   assign pending = pending_r;
   assign irq     = irq_r;
   assign irq_id  = irq_id_r;

endmodule
